// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: fetches one block from pipelined main memory,
// streams each returned word into the data array and writes the tag on the last word.
module cache_fill_fsm #(
    parameter int  BLOCK_WORDS = 8,
    localparam int WI          = $clog2(BLOCK_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          miss_detected,
    input  logic [15:0]   miss_address,
    output logic          fsm_busy,
    output logic [15:0]   memory_address,
    output logic          memory_read_en,
    input  logic          memory_data_valid,
    input  logic [15:0]   memory_data,
    output logic          write_data_array,
    output logic [WI-1:0] word_index,
    output logic          write_tag_array,
    output logic [15:0]   fill_base
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    localparam logic [WI:0]   BLOCK_WORDS_C = (WI+1)'(BLOCK_WORDS);
    localparam logic [WI-1:0] LAST_WORD_C   = WI'(BLOCK_WORDS - 1);
    localparam logic [15:0]   BASE_MASK_C   = ~16'((32'd1 << (WI + 1)) - 32'd1);

    state_t        state_r;
    logic [15:0]   fill_base_r;
    logic [WI:0]   issue_cnt_r;
    logic [WI-1:0] recv_cnt_r;

    // memory_data is wired straight to the data array outside this block
    logic unused_data_s;
    assign unused_data_s = ^memory_data;

    // State, block base and issue/receive counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            fill_base_r <= 16'h0000;
            issue_cnt_r <= '0;
            recv_cnt_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (miss_detected) begin
                        fill_base_r <= miss_address & BASE_MASK_C;
                        issue_cnt_r <= '0;
                        recv_cnt_r  <= '0;
                        state_r     <= ST_FILL;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (memory_read_en) begin
                        issue_cnt_r <= issue_cnt_r + (WI+1)'(1);
                    end else begin
                        issue_cnt_r <= issue_cnt_r;
                    end
                    // miss_detected is ignored here, even on the completion cycle
                    if (memory_data_valid) begin
                        recv_cnt_r <= recv_cnt_r + WI'(1);
                        if (write_tag_array) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_FILL;
                        end
                    end else begin
                        recv_cnt_r <= recv_cnt_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from the registered state and counters
    always_comb begin
        fsm_busy         = 1'b0;
        memory_read_en   = 1'b0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        memory_address   = fill_base_r | 16'({issue_cnt_r, 1'b0});
        word_index       = recv_cnt_r;
        fill_base        = fill_base_r;
        if (state_r == ST_FILL) begin
            fsm_busy         = 1'b1;
            memory_read_en   = (issue_cnt_r < BLOCK_WORDS_C);
            write_data_array = memory_data_valid;
            write_tag_array  = memory_data_valid && (recv_cnt_r == LAST_WORD_C);
        end else begin
            fsm_busy         = 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: 8-word and 4-word instances driven cycle by cycle
// against hand-derived schedules.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = 16'h0000;
    logic        fsm_busy;
    logic [15:0] memory_address;
    logic        memory_read_en;
    logic        memory_data_valid = 1'b0;
    logic [15:0] memory_data = 16'h0000;
    logic        write_data_array;
    logic [2:0]  word_index;
    logic        write_tag_array;
    logic [15:0] fill_base;

    logic        miss4 = 1'b0;
    logic [15:0] miss_addr4 = 16'h0000;
    logic        busy4;
    logic [15:0] mem_addr4;
    logic        rd_en4;
    logic        valid4 = 1'b0;
    logic [15:0] data4 = 16'h0000;
    logic        wda4;
    logic [1:0]  idx4;
    logic        wta4;
    logic [15:0] base4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_fill_fsm #(.BLOCK_WORDS(8)) dut (
        .clk(clk), .rst(rst),
        .miss_detected(miss_detected), .miss_address(miss_address),
        .fsm_busy(fsm_busy), .memory_address(memory_address),
        .memory_read_en(memory_read_en), .memory_data_valid(memory_data_valid),
        .memory_data(memory_data), .write_data_array(write_data_array),
        .word_index(word_index), .write_tag_array(write_tag_array),
        .fill_base(fill_base)
    );

    cache_fill_fsm #(.BLOCK_WORDS(4)) dut4 (
        .clk(clk), .rst(rst),
        .miss_detected(miss4), .miss_address(miss_addr4),
        .fsm_busy(busy4), .memory_address(mem_addr4),
        .memory_read_en(rd_en4), .memory_data_valid(valid4),
        .memory_data(data4), .write_data_array(wda4),
        .word_index(idx4), .write_tag_array(wta4),
        .fill_base(base4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // advance to just after the next rising edge; inputs are driven here
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // per-cycle checks for the 8-word instance
    task automatic check_cycle(input int c, input logic busy_e, input logic rd_e,
                               input logic [15:0] addr_e, input logic wda_e,
                               input logic [2:0] idx_e, input logic wta_e);
        check($sformatf("busy c%0d", c), 32'(fsm_busy), 32'(busy_e));
        check($sformatf("rd_en c%0d", c), 32'(memory_read_en), 32'(rd_e));
        if (rd_e) check($sformatf("addr c%0d", c), 32'(memory_address), 32'(addr_e));
        check($sformatf("wda c%0d", c), 32'(write_data_array), 32'(wda_e));
        if (wda_e) check($sformatf("idx c%0d", c), 32'(word_index), 32'(idx_e));
        check($sformatf("wta c%0d", c), 32'(write_tag_array), 32'(wta_e));
    endtask

    initial begin
        // reset values
        tick();
        #2;
        check("rst busy", 32'(fsm_busy), 32'd0);
        check("rst rd_en", 32'(memory_read_en), 32'd0);
        check("rst wda", 32'(write_data_array), 32'd0);
        check("rst wta", 32'(write_tag_array), 32'd0);
        check("rst addr", 32'(memory_address), 32'd0);
        check("rst base", 32'(fill_base), 32'd0);
        check("rst idx", 32'(word_index), 32'd0);
        check("rst busy4", 32'(busy4), 32'd0);
        rst = 1'b0;
        tick();

        // basic fill: miss 0x1236 at c0, memory latency 4
        for (int c = 0; c <= 14; c++) begin
            tick();
            miss_detected     = (c == 0);
            miss_address      = 16'h1236;
            memory_data_valid = (c >= 5 && c <= 12);
            #2;
            check_cycle(c, (c >= 1 && c <= 12), (c >= 1 && c <= 8),
                        16'(16'h1230 + 2 * (c - 1)), (c >= 5 && c <= 12),
                        3'(c - 5), (c == 12));
            if (c == 1) check("basic base", 32'(fill_base), 32'h1230);
        end

        // bubbled returns: two idle cycles between words 3 and 4
        begin
            int n_writes;
            int valid_cyc [8] = '{5, 6, 7, 8, 11, 12, 13, 14};
            n_writes = 0;
            for (int c = 0; c <= 16; c++) begin
                int pos;
                pos = -1;
                for (int k = 0; k < 8; k++) if (valid_cyc[k] == c) pos = k;
                tick();
                miss_detected     = (c == 0);
                miss_address      = 16'h1236;
                memory_data_valid = (pos >= 0);
                #2;
                if (write_data_array) n_writes++;
                check_cycle(c, (c >= 1 && c <= 14), (c >= 1 && c <= 8),
                            16'(16'h1230 + 2 * (c - 1)), (pos >= 0),
                            3'(pos), (c == 14));
            end
            check("bubble writes", 32'(n_writes), 32'd8);
        end

        // miss held high with a different address while busy
        for (int c = 0; c <= 27; c++) begin
            tick();
            miss_detected     = (c <= 13);
            miss_address      = (c == 0) ? 16'h1236 : 16'h4000;
            memory_data_valid = (c >= 5 && c <= 12) || (c >= 18 && c <= 25);
            #2;
            if (c <= 13) begin
                check_cycle(c, (c >= 1 && c <= 12), (c >= 1 && c <= 8),
                            16'(16'h1230 + 2 * (c - 1)), (c >= 5 && c <= 12),
                            3'(c - 5), (c == 12));
                if (c >= 1 && c <= 12) check($sformatf("hold base c%0d", c), 32'(fill_base), 32'h1230);
            end else begin
                check_cycle(c, (c >= 14 && c <= 25), (c >= 14 && c <= 21),
                            16'(16'h4000 + 2 * (c - 14)), (c >= 18 && c <= 25),
                            3'(c - 18), (c == 25));
                if (c == 14) check("second base", 32'(fill_base), 32'h4000);
            end
        end

        // reset pulse in the middle of a fill
        for (int c = 0; c <= 13; c++) begin
            tick();
            miss_detected     = (c == 0);
            miss_address      = 16'h1236;
            memory_data_valid = (c >= 5 && c <= 12);
            if (c == 7) begin
                rst = 1'b1;
                #1;
                check("midrst busy", 32'(fsm_busy), 32'd0);
                check("midrst rd_en", 32'(memory_read_en), 32'd0);
                check("midrst wda", 32'(write_data_array), 32'd0);
                check("midrst wta", 32'(write_tag_array), 32'd0);
                check("midrst addr", 32'(memory_address), 32'd0);
                check("midrst base", 32'(fill_base), 32'd0);
                check("midrst idx", 32'(word_index), 32'd0);
                rst = 1'b0;
                #1;
            end else begin
                #2;
                check_cycle(c, (c >= 1 && c <= 6), (c >= 1 && c <= 6),
                            16'(16'h1230 + 2 * (c - 1)), (c >= 5 && c <= 6),
                            3'(c - 5), 1'b0);
            end
        end

        // stray valids in IDLE
        for (int c = 0; c <= 3; c++) begin
            tick();
            miss_detected     = 1'b0;
            memory_data_valid = 1'b1;
            #2;
            check_cycle(100 + c, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0);
        end
        memory_data_valid = 1'b0;

        // 4-word instance: miss at 0xFFFE
        for (int c = 0; c <= 10; c++) begin
            tick();
            miss4      = (c == 0);
            miss_addr4 = 16'hFFFE;
            valid4     = (c >= 5 && c <= 8);
            #2;
            check($sformatf("p4 busy c%0d", c), 32'(busy4), 32'((c >= 1 && c <= 8)));
            check($sformatf("p4 rd_en c%0d", c), 32'(rd_en4), 32'((c >= 1 && c <= 4)));
            if (c >= 1 && c <= 4)
                check($sformatf("p4 addr c%0d", c), 32'(mem_addr4), 32'(16'hFFF8 + 2 * (c - 1)));
            check($sformatf("p4 wda c%0d", c), 32'(wda4), 32'((c >= 5 && c <= 8)));
            if (c >= 5 && c <= 8)
                check($sformatf("p4 idx c%0d", c), 32'(idx4), 32'(c - 5));
            check($sformatf("p4 wta c%0d", c), 32'(wta4), 32'((c == 8)));
            if (c == 1) check("p4 base", 32'(base4), 32'hFFF8);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
